// File: rtl/bpsk_modulator.sv
`default_nettype none
// ============================================================================
// Module   : bpsk_modulator (with wave_table_sine)
// Brief    : BPSK transmitter with a bit FIFO, a symbol FSM and a sine table.
//            Optional 1,0,1,0 preamble when BPSK_PREAMBLE_EN is defined.
// Revision : 1.0
// ============================================================================

module wave_table_sine #(
  parameter int DATA_WIDTH = 8
) (
  input  logic [15:0]                  phase,
  output logic signed [DATA_WIDTH-1:0] amp
);

  logic [1:0]       w_quad;
  logic [3:0]       w_idx;
  logic [4:0]       w_sel;
  logic [7:0]       w_mag;
  logic signed [7:0] w_s8;
  logic             w_unused_lsbs;

  assign w_quad        = phase[15:14];
  assign w_idx         = phase[13:10];
  assign w_unused_lsbs = ^phase[9:0];

  // Quarter-wave table, 16 steps per quadrant, peak 127; other quadrants by symmetry.
  always_comb begin
    w_sel = w_quad[0] ? (5'd16 - {1'b0, w_idx}) : {1'b0, w_idx};
    case (w_sel)
      5'd0:    w_mag = 8'd0;
      5'd1:    w_mag = 8'd12;
      5'd2:    w_mag = 8'd25;
      5'd3:    w_mag = 8'd37;
      5'd4:    w_mag = 8'd49;
      5'd5:    w_mag = 8'd60;
      5'd6:    w_mag = 8'd71;
      5'd7:    w_mag = 8'd81;
      5'd8:    w_mag = 8'd90;
      5'd9:    w_mag = 8'd98;
      5'd10:   w_mag = 8'd106;
      5'd11:   w_mag = 8'd112;
      5'd12:   w_mag = 8'd117;
      5'd13:   w_mag = 8'd122;
      5'd14:   w_mag = 8'd125;
      5'd15:   w_mag = 8'd126;
      5'd16:   w_mag = 8'd127;
      default: w_mag = 8'd0;
    endcase
    w_s8 = w_quad[1] ? -$signed(w_mag) : $signed(w_mag);
  end

  if (DATA_WIDTH == 8) begin : g_w8
    assign amp = w_s8;
  end else if (DATA_WIDTH > 8) begin : g_wide
    assign amp = {w_s8, {(DATA_WIDTH-8){1'b0}}};
  end else begin : g_narrow
    assign amp = w_s8[7 -: DATA_WIDTH];
  end

endmodule

module bpsk_modulator #(
  parameter int WAVELENGTH = 64,
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         bit_in,
  input  logic                         bit_valid,
  output logic                         bit_ready,
  output logic signed [DATA_WIDTH-1:0] signal,
  output logic                         symbol_start,
  output logic                         busy
);

  localparam int PW = $clog2(WAVELENGTH);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [PW-1:0] PHASE_LAST = PW'(WAVELENGTH - 1);
  localparam logic [AW:0]   FIFO_FULL  = (AW+1)'(FIFO_DEPTH);
  localparam logic signed [DATA_WIDTH-1:0] AMP_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic signed [DATA_WIDTH-1:0] AMP_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND     = 2'd1
`ifdef BPSK_PREAMBLE_EN
    ,PREAMBLE = 2'd2
`endif
  } state_t;

  // ---------------- input bit FIFO ----------------
  logic [FIFO_DEPTH-1:0] r_fifo;
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [AW:0]           r_count;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_head;

  // Held low combinationally while reset is asserted so nothing is taken in.
  assign bit_ready = reset_n && (r_count != FIFO_FULL);
  assign w_push    = bit_valid && bit_ready;
  assign w_head    = r_fifo[r_rd_ptr];

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_fifo[r_wr_ptr] <= bit_in;
        r_wr_ptr         <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // ---------------- symbol FSM ----------------
  state_t        r_state;
  state_t        w_state_nxt;
  logic [PW-1:0] r_phase;
  logic [PW-1:0] w_phase_nxt;
  logic          r_cur_bit;
  logic          w_cur_bit_nxt;
  logic          w_tx_bit;
`ifdef BPSK_PREAMBLE_EN
  logic [1:0]    r_pre_cnt;
  logic [1:0]    w_pre_cnt_nxt;
`endif

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_phase   <= '0;
      r_cur_bit <= 1'b0;
`ifdef BPSK_PREAMBLE_EN
      r_pre_cnt <= 2'd0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_phase   <= w_phase_nxt;
      r_cur_bit <= w_cur_bit_nxt;
`ifdef BPSK_PREAMBLE_EN
      r_pre_cnt <= w_pre_cnt_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_phase_nxt   = r_phase;
    w_cur_bit_nxt = r_cur_bit;
    w_pop         = 1'b0;
`ifdef BPSK_PREAMBLE_EN
    w_pre_cnt_nxt = r_pre_cnt;
`endif
    case (r_state)
      IDLE: begin
        w_phase_nxt = '0;
        if (r_count != '0) begin
          w_pop         = 1'b1;
          w_cur_bit_nxt = w_head;
`ifdef BPSK_PREAMBLE_EN
          w_state_nxt   = PREAMBLE;
          w_pre_cnt_nxt = 2'd0;
`else
          w_state_nxt   = SEND;
`endif
        end
      end
      SEND: begin
        if (r_phase == PHASE_LAST) begin
          w_phase_nxt = '0;
          if (r_count != '0) begin
            w_pop         = 1'b1;
            w_cur_bit_nxt = w_head;
          end else begin
            w_state_nxt = IDLE;
          end
        end else begin
          w_phase_nxt = r_phase + 1'b1;
        end
      end
`ifdef BPSK_PREAMBLE_EN
      PREAMBLE: begin
        if (r_phase == PHASE_LAST) begin
          w_phase_nxt = '0;
          if (r_pre_cnt == 2'd3) begin
            w_state_nxt = SEND;
          end else begin
            w_pre_cnt_nxt = r_pre_cnt + 2'd1;
          end
        end else begin
          w_phase_nxt = r_phase + 1'b1;
        end
      end
`endif
      default: begin
        w_state_nxt = IDLE;
        w_phase_nxt = '0;
      end
    endcase
  end

`ifdef BPSK_PREAMBLE_EN
  // Preamble symbols alternate 1,0,1,0 starting with 1.
  assign w_tx_bit = (r_state == PREAMBLE) ? ~r_pre_cnt[0] : r_cur_bit;
`else
  assign w_tx_bit = r_cur_bit;
`endif

  // ---------------- carrier generation ----------------
  logic [15:0]                  w_tab_phase;
  logic signed [DATA_WIDTH-1:0] w_amp;
  logic signed [DATA_WIDTH-1:0] w_neg_amp;

  // Spread one symbol's phase steps over the table's full 16-bit circle.
  assign w_tab_phase = 16'((32'(r_phase) << 16) / 32'(WAVELENGTH));

  wave_table_sine #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_wave_table_sine (
    .phase (w_tab_phase),
    .amp   (w_amp)
  );

  assign w_neg_amp = (w_amp == AMP_MIN) ? AMP_MAX : -w_amp;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      signal       <= '0;
      symbol_start <= 1'b0;
      busy         <= 1'b0;
    end else if (r_state == IDLE) begin
      signal       <= '0;
      symbol_start <= 1'b0;
      busy         <= 1'b0;
    end else begin
      signal       <= w_tx_bit ? w_neg_amp : w_amp;
      symbol_start <= (r_phase == '0);
      busy         <= 1'b1;
    end
  end

endmodule
`default_nettype wire
